// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory port arbiter.
// Widths match the 2048 x 32 instruction BSRAM.
package imem_pkg;

   localparam int IMEM_ADDR_W = 11;
   localparam int IMEM_DATA_W = 32;
   localparam int BURST_W     = 4;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_LOCK = 1'b1
   } arb_state_e;

   // One flag per requester: which one owns the read data arriving next cycle.
   typedef struct packed {
      logic rsp_if;
      logic rsp_ld;
   } rsp_tag_t;

endpackage

// File: rtl/imem_port_arbiter_if.sv
// Requester and BSRAM pin bundle for the instruction-memory arbiter.
// slave = arbiter side, master = fetch/loader/BSRAM side.
interface imem_port_arbiter_if;

   logic                               if_req;
   logic [imem_pkg::IMEM_ADDR_W-1:0]   if_addr;
   logic                               if_gnt;
   logic                               if_rvalid;
   logic [imem_pkg::IMEM_DATA_W-1:0]   if_rdata;

   logic                               ld_req;
   logic                               ld_we;
   logic [imem_pkg::IMEM_ADDR_W-1:0]   ld_addr;
   logic [imem_pkg::IMEM_DATA_W-1:0]   ld_wdata;
   logic                               ld_gnt;
   logic                               ld_rvalid;
   logic [imem_pkg::IMEM_DATA_W-1:0]   ld_rdata;
   logic                               ld_lock;
   logic                               cpu_hold;

   logic                               mem_ce;
   logic                               mem_oce;
   logic                               mem_reset;
   logic                               mem_wre;
   logic [imem_pkg::IMEM_ADDR_W-1:0]   mem_ad;
   logic [imem_pkg::IMEM_DATA_W-1:0]   mem_din;
   logic [imem_pkg::IMEM_DATA_W-1:0]   mem_dout;

   modport slave (
      input  if_req, if_addr,
      output if_gnt, if_rvalid, if_rdata,
      input  ld_req, ld_we, ld_addr, ld_wdata, ld_lock,
      output ld_gnt, ld_rvalid, ld_rdata, cpu_hold,
      output mem_ce, mem_oce, mem_reset, mem_wre, mem_ad, mem_din,
      input  mem_dout
   );

   modport master (
      output if_req, if_addr,
      input  if_gnt, if_rvalid, if_rdata,
      output ld_req, ld_we, ld_addr, ld_wdata, ld_lock,
      input  ld_gnt, ld_rvalid, ld_rdata, cpu_hold,
      input  mem_ce, mem_oce, mem_reset, mem_wre, mem_ad, mem_din,
      output mem_dout
   );

endinterface

// File: rtl/imem_arb_core.sv
// Per-cycle grant decision between fetch and loader, with a bounded loader
// burst so fetch cannot be starved while the block is running.
module imem_arb_core
   import imem_pkg::*;
#(
   parameter int LD_MAX_BURST = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic i_lock,
   input  logic i_if_req,
   input  logic i_ld_req,
   output logic o_if_gnt,
   output logic o_ld_gnt
);

   localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(LD_MAX_BURST);

   logic [BURST_W-1:0] r_burst_cnt;
   logic               w_burst_full;

   always_comb begin
      o_if_gnt     = 1'b0;
      o_ld_gnt     = 1'b0;
      w_burst_full = (r_burst_cnt == BURST_LIMIT);
      if (!reset) begin
         if (i_lock) begin
            o_ld_gnt = i_ld_req;
         end else if (i_ld_req && !(i_if_req && w_burst_full)) begin
            o_ld_gnt = 1'b1;
         end else if (i_if_req) begin
            o_if_gnt = 1'b1;
         end
      end
   end

   // Counts only loader grants that made fetch wait; anything else restarts it.
   always_ff @(posedge clk) begin
      if (reset || i_lock) begin
         r_burst_cnt <= '0;
      end else if (o_ld_gnt && i_if_req) begin
         r_burst_cnt <= r_burst_cnt + 1'b1;
      end else begin
         r_burst_cnt <= '0;
      end
   end

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares the single-port instruction BSRAM between CPU fetch and the program
// loader; owns the RUN/LOCK state, response tags and BSRAM pin mux.
module imem_port_arbiter
   import imem_pkg::*;
#(
   parameter int ADDR_W       = IMEM_ADDR_W,
   parameter int DATA_W       = IMEM_DATA_W,
   parameter int LD_MAX_BURST = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   imem_port_arbiter_if.slave    bus
);

   arb_state_e          r_state;
   logic                r_cpu_hold;
   rsp_tag_t            r_rsp;

   logic                w_lock;
   logic                w_if_gnt;
   logic                w_ld_gnt;
   logic [ADDR_W-1:0]   w_mem_ad;
   logic [DATA_W-1:0]   w_mem_din;

   // The cycle that requests LOCK already blocks fetch.
   assign w_lock = (r_state == ST_LOCK) || bus.ld_lock;

   imem_arb_core #(
      .LD_MAX_BURST (LD_MAX_BURST)
   ) u_core (
      .clk      (clk),
      .reset    (reset),
      .i_lock   (w_lock),
      .i_if_req (bus.if_req),
      .i_ld_req (bus.ld_req),
      .o_if_gnt (w_if_gnt),
      .o_ld_gnt (w_ld_gnt)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_RUN;
         r_cpu_hold <= 1'b0;
         r_rsp      <= '0;
      end else begin
         r_state    <= bus.ld_lock ? ST_LOCK : ST_RUN;
         r_cpu_hold <= bus.ld_lock;
         r_rsp.rsp_if <= w_if_gnt;
         r_rsp.rsp_ld <= w_ld_gnt && !bus.ld_we;
      end
   end

   always_comb begin
      w_mem_ad  = '0;
      w_mem_din = '0;
      if (w_if_gnt) begin
         w_mem_ad = bus.if_addr;
      end else if (w_ld_gnt) begin
         w_mem_ad  = bus.ld_addr;
         w_mem_din = bus.ld_wdata;
      end
   end

   assign bus.if_gnt    = w_if_gnt;
   assign bus.ld_gnt    = w_ld_gnt;
   assign bus.cpu_hold  = r_cpu_hold;
   assign bus.mem_ce    = w_if_gnt | w_ld_gnt;
   assign bus.mem_oce   = 1'b1;
   assign bus.mem_reset = reset;
   assign bus.mem_wre   = w_ld_gnt & bus.ld_we;
   assign bus.mem_ad    = w_mem_ad;
   assign bus.mem_din   = w_mem_din;

   // A response in flight when reset arrives is discarded immediately.
   assign bus.if_rvalid = r_rsp.rsp_if && !reset;
   assign bus.ld_rvalid = r_rsp.rsp_ld && !reset;
   assign bus.if_rdata  = bus.mem_dout;
   assign bus.ld_rdata  = bus.mem_dout;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed vector table plus randomized traffic against a rule-level model
// for the instruction-memory port arbiter, with a behavioural BSRAM.
module tb_imem_port_arbiter;

   localparam int LD_MAX = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   imem_port_arbiter_if bus ();

   imem_port_arbiter #(
      .ADDR_W       (11),
      .DATA_W       (32),
      .LD_MAX_BURST (LD_MAX)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   function automatic logic [31:0] init_word(input int i);
      return (i == 0) ? 32'h00500113 : (32'hA5A50000 | 32'(i));
   endfunction

   // BSRAM: one-cycle read latency, normal write mode, preloaded on first edge.
   logic [31:0] bsram [0:2047];
   bit          loaded;
   always @(posedge clk) begin
      if (!loaded) begin
         for (int i = 0; i < 2048; i++) bsram[i] <= init_word(i);
         loaded <= 1'b1;
      end else if (bus.mem_reset) begin
         bus.mem_dout <= '0;
      end else if (bus.mem_ce) begin
         if (bus.mem_wre) bsram[bus.mem_ad] <= bus.mem_din;
         else             bus.mem_dout <= bsram[bus.mem_ad];
      end
   end

   typedef struct {
      logic        rst, if_req;
      logic [10:0] if_addr;
      logic        ld_req, ld_we;
      logic [10:0] ld_addr;
      logic [31:0] ld_wdata;
      logic        ld_lock;
      logic        e_if_gnt, e_ld_gnt, e_if_rv, e_ld_rv;
      logic [31:0] e_rdata;
      logic        e_hold, e_wre;
      logic [10:0] e_ad;
   } vec_t;

   function automatic vec_t mk(input logic rst, iq, input int ia, input logic lq, lw,
                               input int la, input logic [31:0] wd, input logic lk,
                               input logic eig, elg, eiv, elv, input logic [31:0] erd,
                               input logic eh, ew, input int ead);
      vec_t v;
      v.rst = rst; v.if_req = iq; v.if_addr = 11'(ia);
      v.ld_req = lq; v.ld_we = lw; v.ld_addr = 11'(la); v.ld_wdata = wd; v.ld_lock = lk;
      v.e_if_gnt = eig; v.e_ld_gnt = elg; v.e_if_rv = eiv; v.e_ld_rv = elv;
      v.e_rdata = erd; v.e_hold = eh; v.e_wre = ew; v.e_ad = 11'(ead);
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      reset        = v.rst;
      bus.if_req   = v.if_req;
      bus.if_addr  = v.if_addr;
      bus.ld_req   = v.ld_req;
      bus.ld_we    = v.ld_we;
      bus.ld_addr  = v.ld_addr;
      bus.ld_wdata = v.ld_wdata;
      bus.ld_lock  = v.ld_lock;
   endtask

   // Reference model: rules stated in terms of "who owns the port" and
   // "how many loader wins fetch has already sat through".
   bit          m_lock;
   int          m_loader_wins;
   bit          m_pend_if, m_pend_ld;
   logic [31:0] m_pend_data;
   logic [31:0] ref_mem [0:2047];

   task automatic step(input bit use_tbl, input vec_t v, input string tag,
                       output bit g_if, output bit g_ld);
      bit fetch_blocked, fetch_due, e_if_rv, e_ld_rv;
      @(negedge clk);
      fetch_blocked = m_lock || bus.ld_lock;
      fetch_due     = !fetch_blocked && bus.if_req && (m_loader_wins >= LD_MAX);
      g_if = 1'b0;
      g_ld = 1'b0;
      if (!reset) begin
         if (bus.ld_req && !fetch_due) g_ld = 1'b1;
         else if (bus.if_req && !fetch_blocked) g_if = 1'b1;
      end
      e_if_rv = m_pend_if && !reset;
      e_ld_rv = m_pend_ld && !reset;

      if (use_tbl) begin
         chk({tag, " if_gnt"},    bus.if_gnt,    v.e_if_gnt);
         chk({tag, " ld_gnt"},    bus.ld_gnt,    v.e_ld_gnt);
         chk({tag, " if_rvalid"}, bus.if_rvalid, v.e_if_rv);
         chk({tag, " ld_rvalid"}, bus.ld_rvalid, v.e_ld_rv);
         if (v.e_if_rv) chk({tag, " if_rdata"}, bus.if_rdata, v.e_rdata);
         if (v.e_ld_rv) chk({tag, " ld_rdata"}, bus.ld_rdata, v.e_rdata);
         chk({tag, " cpu_hold"},  bus.cpu_hold,  v.e_hold);
         chk({tag, " mem_wre"},   bus.mem_wre,   v.e_wre);
         chk({tag, " mem_ad"},    32'(bus.mem_ad), 32'(v.e_ad));
         chk({tag, " mem_ce"},    bus.mem_ce,    v.e_if_gnt | v.e_ld_gnt);
         chk({tag, " mem_oce"},   bus.mem_oce,   1'b1);
         chk({tag, " mem_reset"}, bus.mem_reset, v.rst);
      end else begin
         chk({tag, " if_gnt"},    bus.if_gnt,    g_if);
         chk({tag, " ld_gnt"},    bus.ld_gnt,    g_ld);
         chk({tag, " if_rvalid"}, bus.if_rvalid, e_if_rv);
         chk({tag, " ld_rvalid"}, bus.ld_rvalid, e_ld_rv);
         if (e_if_rv) chk({tag, " if_rdata"}, bus.if_rdata, m_pend_data);
         if (e_ld_rv) chk({tag, " ld_rdata"}, bus.ld_rdata, m_pend_data);
         chk({tag, " cpu_hold"},  bus.cpu_hold,  m_lock);
         chk({tag, " mem_wre"},   bus.mem_wre,   g_ld && bus.ld_we);
         chk({tag, " mem_ce"},    bus.mem_ce,    g_if || g_ld);
         chk({tag, " mem_ad"},    32'(bus.mem_ad),
             g_if ? 32'(bus.if_addr) : (g_ld ? 32'(bus.ld_addr) : 32'd0));
         if (g_ld && bus.ld_we) chk({tag, " mem_din"}, bus.mem_din, bus.ld_wdata);
      end

      m_pend_if = 1'b0;
      m_pend_ld = 1'b0;
      if (!reset) begin
         if (g_if) begin
            m_pend_if   = 1'b1;
            m_pend_data = ref_mem[bus.if_addr];
         end else if (g_ld && !bus.ld_we) begin
            m_pend_ld   = 1'b1;
            m_pend_data = ref_mem[bus.ld_addr];
         end else if (g_ld) begin
            ref_mem[bus.ld_addr] = bus.ld_wdata;
         end
      end
      m_loader_wins = (!reset && !fetch_blocked && g_ld && bus.if_req) ? m_loader_wins + 1 : 0;
      m_lock = reset ? 1'b0 : bus.ld_lock;
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t        vecs[$];
      vec_t        dummy;
      bit          g_if, g_ld;
      logic [31:0] w0, w1, w2, w3, w4, w6, w10;

      for (int i = 0; i < 2048; i++) ref_mem[i] = init_word(i);
      m_lock = 1'b0; m_loader_wins = 0; m_pend_if = 1'b0; m_pend_ld = 1'b0; m_pend_data = '0;
      w0 = init_word(0); w1 = init_word(1); w2 = init_word(2); w3 = init_word(3);
      w4 = init_word(4); w6 = init_word(6); w10 = init_word(10);
      dummy = mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0);

      // reset, then fetch-only reads of 0,1,2
      vecs.push_back(mk(1,1,0,1,0,9,0,0, 0,0,0,0,0,0,0,0));
      vecs.push_back(mk(1,1,0,1,0,9,0,0, 0,0,0,0,0,0,0,0));
      vecs.push_back(mk(0,1,0,0,0,0,0,0, 1,0,0,0,0,0,0,0));
      vecs.push_back(mk(0,1,1,0,0,0,0,0, 1,0,1,0,w0,0,0,1));
      vecs.push_back(mk(0,1,2,0,0,0,0,0, 1,0,1,0,w1,0,0,2));
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,1,0,w2,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0));
      // starvation limit: L,L,L,L,F repeating
      for (int k = 0; k < 10; k++) begin
         bit is_f, prev_f;
         is_f   = (k % 5) == 4;
         prev_f = (k % 5) == 0;
         vecs.push_back(mk(0,1,3,1,0,10,0,0, is_f, !is_f,
                           (k > 0) && prev_f, (k > 0) && !prev_f,
                           prev_f ? w3 : w10, 0,0, is_f ? 3 : 10));
      end
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,1,0,w3,0,0,0));
      // lock and load at 0x7FF
      vecs.push_back(mk(0,1,4,0,0,0,0,1, 0,0,0,0,0,0,0,0));
      vecs.push_back(mk(0,1,4,1,1,'h7FF,32'hDEADBEEF,1, 0,1,0,0,0,1,1,'h7FF));
      vecs.push_back(mk(0,1,4,1,0,'h7FF,0,1, 0,1,0,0,0,1,0,'h7FF));
      vecs.push_back(mk(0,1,4,0,0,0,0,1, 0,0,0,1,32'hDEADBEEF,1,0,0));
      vecs.push_back(mk(0,1,4,0,0,0,0,0, 0,0,0,0,0,1,0,0));
      vecs.push_back(mk(0,1,4,0,0,0,0,0, 1,0,0,0,0,0,0,4));
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,1,0,w4,0,0,0));
      // write then immediate read of addr 5
      vecs.push_back(mk(0,0,0,1,1,5,32'h12345678,0, 0,1,0,0,0,0,1,5));
      vecs.push_back(mk(0,0,0,1,0,5,0,0, 0,1,0,0,0,0,0,5));
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,1,32'h12345678,0,0,0));
      // reset one cycle after a fetch grant
      vecs.push_back(mk(0,1,6,0,0,0,0,0, 1,0,0,0,0,0,0,6));
      vecs.push_back(mk(1,1,6,1,0,9,0,0, 0,0,0,0,0,0,0,0));
      vecs.push_back(mk(1,1,6,1,0,9,0,0, 0,0,0,0,0,0,0,0));
      vecs.push_back(mk(0,1,6,0,0,0,0,0, 1,0,0,0,0,0,0,6));
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,1,0,w6,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0));

      apply(vecs[0]);
      bus.mem_dout = '0;
      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i]);
         step(1'b1, vecs[i], $sformatf("vec%0d", i), g_if, g_ld);
         $display("vec %0d rst=%0d if_req=%0d ld_req=%0d we=%0d lock=%0d -> if_gnt=%0d ld_gnt=%0d",
                  i, vecs[i].rst, vecs[i].if_req, vecs[i].ld_req, vecs[i].ld_we,
                  vecs[i].ld_lock, g_if, g_ld);
      end

      // randomized traffic; requesters hold their request until granted
      begin
         int n_if = 0, n_ld = 0;
         for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 39) == 0) bus.ld_lock = !bus.ld_lock;
            if (!bus.if_req) begin
               bus.if_req  = ($urandom_range(0, 3) != 0);
               bus.if_addr = ($urandom_range(0, 3) == 0) ? 11'($urandom) : 11'($urandom_range(0, 15));
            end
            if (!bus.ld_req) begin
               bus.ld_req   = ($urandom_range(0, 2) != 0);
               bus.ld_we    = $urandom_range(0, 1) != 0;
               bus.ld_addr  = 11'($urandom_range(0, 15));
               bus.ld_wdata = $urandom;
            end
            step(1'b0, dummy, $sformatf("rnd%0d", c), g_if, g_ld);
            if (g_if) begin bus.if_req = 1'b0; n_if++; end
            if (g_ld) begin bus.ld_req = 1'b0; n_ld++; end
         end
         $display("random phase: fetch grants=%0d loader grants=%0d", n_if, n_ld);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Shares the single-port 8 KB instruction BSRAM (2048 x 32, one-cycle read latency, single word-wide write enable) between two requesters: CPU instruction fetch (read-only) and the program loader (read/write, debug/UART side).
- Arbitrates per cycle, drives the BSRAM control pins, and routes each read response to the requester that issued it.
- Provides an exclusive-load mode that holds the CPU while a program image is written.

Parameters:
- ADDR_W, 11, word address width (2048 words).
- DATA_W, 32, word width.
- LD_MAX_BURST, 4, maximum consecutive loader grants while fetch is waiting, in RUN state (range 1..15).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch read request.
- if_addr  in  ADDR_W  fetch word address.
- if_gnt  out  1  fetch request accepted this cycle (combinational).
- if_rvalid  out  1  fetch read data valid.
- if_rdata  out  DATA_W  fetch read data.
- ld_req  in  1  loader request.
- ld_we  in  1  loader write (1) or read (0).
- ld_addr  in  ADDR_W  loader word address.
- ld_wdata  in  DATA_W  loader write data.
- ld_gnt  out  1  loader request accepted this cycle (combinational).
- ld_rvalid  out  1  loader read data valid.
- ld_rdata  out  DATA_W  loader read data.
- ld_lock  in  1  loader requests exclusive mode.
- cpu_hold  out  1  CPU must stall; the block is in LOCK.
- mem_ce  out  1  BSRAM clock enable.
- mem_oce  out  1  BSRAM output clock enable; tied 1.
- mem_reset  out  1  BSRAM output reset; equals reset.
- mem_wre  out  1  BSRAM write enable.
- mem_ad  out  ADDR_W  BSRAM word address.
- mem_din  out  DATA_W  BSRAM write data.
- mem_dout  in  DATA_W  BSRAM read data.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- At most one grant per cycle. mem_ce = if_gnt | ld_gnt.
  - mem_ad and mem_din come from the granted requester; they are 0 when no grant.
  - mem_wre = ld_gnt & ld_we.
- State machine: RUN (reset state) and LOCK.
  - RUN -> LOCK on a cycle where ld_lock=1. The transition cycle is already treated as LOCK for arbitration: no fetch grant.
  - LOCK -> RUN on a cycle where ld_lock=0. Fetch is eligible from the next cycle.
  - cpu_hold = 1 in LOCK. It is registered: it rises the cycle after ld_lock is sampled 1 and falls the cycle after ld_lock is sampled 0.
- RUN arbitration:
  - Loader has priority, with a 4-bit counter burst_cnt of consecutive loader grants made while if_req=1.
  - When burst_cnt == LD_MAX_BURST and if_req=1, fetch is granted and burst_cnt clears.
  - burst_cnt also clears on any cycle with if_req=0 or no loader grant.
- LOCK arbitration: only the loader is granted; if_gnt=0 and burst_cnt is held at 0.
- Response routing:
  - A registered tag (rsp_if, rsp_ld) is set for a granted read.
  - if_rvalid/ld_rvalid assert exactly one cycle after the grant.
  - rdata outputs = mem_dout. Data is defined only while rvalid=1.
  - Writes produce no rvalid.
- Back-to-back: one read response per cycle is sustained; responses of the two requesters may interleave on consecutive cycles.
- Read after write to the same address on the next cycle returns the new data. This holds because the BSRAM write mode is normal.
- Reset (including mid-operation): state=RUN, cpu_hold=0, burst_cnt=0, rvalid tags cleared. An in-flight read response is dropped.
  - While reset=1, if_gnt=ld_gnt=0, mem_ce=0 and mem_wre=0.
- Requesters hold req/addr/wdata stable until gnt. Requests are not queued internally.

Decomposition:
- Shared package imem_pkg holds:
  - IMEM_ADDR_W=11 and IMEM_DATA_W=32.
  - The state encoding (ST_RUN=1'b0, ST_LOCK=1'b1).
  - The response-tag typedef {rsp_if, rsp_ld}.
- One natural sub-module: imem_arb_core, the combinational grant logic plus burst_cnt. The top level owns the state register, response tags and BSRAM pin mux.

Test Plan:
- Reset then fetch only: if_req=1 at addrs 0,1,2 on consecutive cycles -> if_gnt=1 each cycle; if_rvalid=1 on cycles +1..+3 with words read from preloaded addresses 0,1,2 (e.g. 0x00500113 at 0); ld_rvalid=0 throughout.
- Starvation limit, LD_MAX_BURST=4: ld_req=1 (reads) and if_req=1 continuously -> grant pattern L,L,L,L,F repeating; each read response goes to its issuer one cycle after its grant.
- Lock and load:
  - ld_lock=1, then loader writes 0xDEADBEEF to addr 0x7FF; if_req held 1.
  - Expected: if_gnt=0 and cpu_hold=1 from the next cycle; mem_wre=1 with mem_ad=0x7FF.
  - Then a loader read of 0x7FF -> ld_rvalid=1, ld_rdata=0xDEADBEEF.
  - Drop ld_lock -> cpu_hold=0 next cycle and fetch granted.
- Write then immediate read: loader writes 0x12345678 to addr 5 at cycle N and reads addr 5 at cycle N+1 -> ld_rvalid at N+2 with 0x12345678; no rvalid at N+1.
- Reset mid-operation: fetch read granted at cycle N, reset=1 at N+1 -> if_rvalid=0 at N+1, cpu_hold=0, no grants while reset=1; after reset release, first fetch read is granted and returns data one cycle later.
